// File: rtl/fir_cfg_sequencer_pkg.sv
// Shared constants, profile-word field layout and sequencer state encoding
// for the FIR run-time profile controller.
package fir_cfg_sequencer_pkg;

  localparam int unsigned APB_AW = 4;
  localparam int unsigned APB_DW = 32;

  localparam logic [APB_AW-1:0] FIR_REG_GAIN = 4'h0;
  localparam logic [APB_AW-1:0] FIR_REG_COEF = 4'h8;
  localparam logic [APB_AW-1:0] FIR_REG_CTAP = 4'hC;

  localparam int unsigned PROF_W   = 42;
  localparam int unsigned COEF_LSB = 0;
  localparam int unsigned COEF_MSB = 31;
  localparam int unsigned CTAP_LSB = 32;
  localparam int unsigned CTAP_MSB = 39;
  localparam int unsigned GAIN_LSB = 40;
  localparam int unsigned GAIN_MSB = 41;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_ARMED,
    ST_W2S,
    ST_W2A,
    ST_W3S,
    ST_W3A,
    ST_W0S,
    ST_W0A
  } seq_state_e;

  function automatic logic [APB_DW-1:0] prof_coef(input logic [PROF_W-1:0] p);
    return p[COEF_MSB:COEF_LSB];
  endfunction

  function automatic logic [APB_DW-1:0] prof_ctap(input logic [PROF_W-1:0] p);
    return {24'b0, p[CTAP_MSB:CTAP_LSB]};
  endfunction

  function automatic logic [APB_DW-1:0] prof_gain(input logic [PROF_W-1:0] p);
    return {30'b0, p[GAIN_MSB:GAIN_LSB]};
  endfunction

endpackage

// File: rtl/fir_cfg_sequencer_apb_wr_master.sv
// Single-write APB engine: a start pulse launches SETUP then ACCESS, held
// until pready; done_o marks the completing ACCESS cycle.
module apb_wr_master
  import fir_cfg_sequencer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [APB_AW-1:0] addr_i,
  input  logic [APB_DW-1:0] data_i,
  output logic              done_o,
  output logic [APB_AW-1:0] paddr_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [APB_DW-1:0] pwdata_o,
  input  logic              pready_i
);

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic [APB_DW-1:0] pwdata_q, pwdata_d;

  // A start in the done cycle chains straight into the next SETUP phase.
  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_o    = penable_q & pready_i;
    if (done_o) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end else if (psel_q) begin
      penable_d = 1'b1;
    end
    if (start_i) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      paddr_d   = addr_i;
      pwdata_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= psel_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign paddr_o   = paddr_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: rtl/fir_cfg_sequencer.sv
// Profile controller: holds four FIR profiles and, on request, stalls the
// sample stream at a frame boundary while the FIR registers are reprogrammed.
module fir_cfg_sequencer
  import fir_cfg_sequencer_pkg::*;
#(
  parameter int unsigned NPROF = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prof_we,
  input  logic [$clog2(NPROF)-1:0] prof_waddr,
  input  logic [PROF_W-1:0]        prof_wdata,
  input  logic                     sw_req,
  input  logic [$clog2(NPROF)-1:0] sw_idx,
  output logic                     sw_busy,
  output logic                     sw_done,
  output logic [$clog2(NPROF)-1:0] active_idx,
  input  logic [DW-1:0]            s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  output logic [DW-1:0]            m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [APB_AW-1:0]        paddr,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [APB_DW-1:0]        pwdata,
  input  logic                     pready
);

  localparam int unsigned IW = $clog2(NPROF);

  seq_state_e        state_q, state_d;
  logic [PROF_W-1:0] prof_q [NPROF];
  logic [PROF_W-1:0] shadow_q, shadow_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     active_q, active_d;
  logic              in_frame_q, in_frame_d;
  logic              done_q, done_d;

  logic              pass;
  logic              beat;
  logic              wr_start;
  logic              wr_done;
  logic [APB_AW-1:0] wr_addr;
  logic [APB_DW-1:0] wr_data;

  assign pass     = (state_q == ST_RUN) || (state_q == ST_ARMED);
  assign m_tvalid = s_tvalid & pass;
  assign s_tready = m_tready & pass;
  assign m_tdata  = s_tdata;
  assign m_tlast  = s_tlast;
  assign beat     = s_tvalid & s_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NPROF; i++) prof_q[i] <= '0;
    end else if (prof_we) begin
      prof_q[prof_waddr] <= prof_wdata;
    end
  end

  // Each write is launched on the transition into its SETUP state so the
  // engine's registered APB outputs line up with the xS/xA states.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    active_d   = active_q;
    done_d     = 1'b0;
    in_frame_d = in_frame_q;
    wr_start   = 1'b0;
    wr_addr    = FIR_REG_COEF;
    wr_data    = prof_coef(shadow_q);
    if (beat) in_frame_d = ~s_tlast;
    case (state_q)
      ST_RUN: begin
        if (sw_req) begin
          shadow_d = prof_q[sw_idx];
          idx_d    = sw_idx;
          state_d  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!in_frame_q || (beat && s_tlast)) begin
          wr_start = 1'b1;
          state_d  = ST_W2S;
        end
      end
      ST_W2S: state_d = ST_W2A;
      ST_W2A: begin
        if (wr_done) begin
          wr_start = 1'b1;
          wr_addr  = FIR_REG_CTAP;
          wr_data  = prof_ctap(shadow_q);
          state_d  = ST_W3S;
        end
      end
      ST_W3S: state_d = ST_W3A;
      ST_W3A: begin
        if (wr_done) begin
          wr_start = 1'b1;
          wr_addr  = FIR_REG_GAIN;
          wr_data  = prof_gain(shadow_q);
          state_d  = ST_W0S;
        end
      end
      ST_W0S: state_d = ST_W0A;
      ST_W0A: begin
        if (wr_done) begin
          done_d   = 1'b1;
          active_d = idx_q;
          state_d  = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      shadow_q   <= '0;
      idx_q      <= '0;
      active_q   <= '0;
      in_frame_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      active_q   <= active_d;
      in_frame_q <= in_frame_d;
      done_q     <= done_d;
    end
  end

  assign sw_busy    = (state_q != ST_RUN);
  assign sw_done    = done_q;
  assign active_idx = active_q;

  apb_wr_master u_apb (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (wr_start),
    .addr_i    (wr_addr),
    .data_i    (wr_data),
    .done_o    (wr_done),
    .paddr_o   (paddr),
    .psel_o    (psel),
    .penable_o (penable),
    .pwrite_o  (pwrite),
    .pwdata_o  (pwdata),
    .pready_i  (pready)
  );

endmodule

// File: doc/fir_cfg_sequencer.md
# fir_cfg_sequencer

Run-time profile controller for the 9-tap symmetric FIR block. It stores four coefficient/gain profiles and accepts a host profile-switch request. At the next AXI4-Stream frame boundary it stalls the sample stream into the FIR, programs the FIR's APB register file with the chosen profile, then resumes streaming. It sits between the upstream sample source and the FIR's slave stream port, and is the sole APB master on the FIR's register interface.

## Interface
- `NPROF`, 4: number of stored profiles; the index width is 2 bits.
- `DW`, 8: stream data width; passed through unchanged.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `prof_we`  in  1  profile write strobe.
- `prof_waddr`  in  2  profile index to write.
- `prof_wdata`  in  42  profile word, laid out as follows:
  - [31:0] is the FIR coeff-pair word (c0..c3).
  - [39:32] is the centre tap c4.
  - [41:40] is the gain select.
- `sw_req`  in  1  request a switch to profile `sw_idx`; single-cycle pulse.
- `sw_idx`  in  2  requested profile.
- `sw_busy`  out  1  high from request acceptance until the switch completes.
- `sw_done`  out  1  one-cycle pulse when the new profile is active.
- `active_idx`  out  2  index of the profile currently programmed in the FIR.
- `s_tdata`/`s_tvalid`/`s_tready`/`s_tlast`  in/in/out/in  DW/1/1/1  upstream stream.
- `m_tdata`/`m_tvalid`/`m_tready`/`m_tlast`  out/out/in/out  DW/1/1/1  stream to the FIR.
- `paddr`  out  4  APB address to the FIR.
- `psel`, `penable`, `pwrite`  out  1 each  APB control to the FIR.
- `pwdata`  out  32  APB write data to the FIR.
- `pready`  in  1  APB ready from the FIR.

## Operation
**Profile RAM**
- 4 × 42-bit flops, all zero on reset.
- `prof_we` writes at the clock edge.
- When a request is accepted, the selected profile is copied into a shadow register. A later `prof_we` to the same index does not affect a switch already in progress.

**Pass-through**
- `pass` = state ∈ {RUN, ARMED}.
- `m_tvalid` = `s_tvalid` & `pass`; `s_tready` = `m_tready` & `pass`.
- `m_tdata` = `s_tdata`; `m_tlast` = `s_tlast`. This path is combinational.

**Frame tracking**
- `in_frame` sets on any accepted beat (`s_tvalid` & `s_tready`) with `s_tlast`=0.
- `in_frame` clears on an accepted beat with `s_tlast`=1.

**FSM states:** RUN, ARMED, W2S, W2A, W3S, W3A, W0S, W0A.
- RUN: if `sw_req`, latch `sw_idx` and the shadow profile, set `sw_busy`, and go to ARMED.
- ARMED: the stream still passes.
  - If `in_frame`=0, go to W2S.
  - Otherwise, on an accepted beat with `s_tlast`=1, go to W2S.
- Write sequence: each xS state is the APB SETUP phase (`psel`=1, `penable`=0). Each xA state is the ACCESS phase (`psel`=1, `penable`=1), held until `pready`=1.
  - W2S/W2A: `paddr`=0x8, `pwdata`=profile[31:0].
  - W3S/W3A: `paddr`=0xC, `pwdata`={24'b0, profile[39:32]}.
  - W0S/W0A: `paddr`=0x0, `pwdata`={30'b0, profile[41:40]}.
  - `pwrite`=1 throughout.
- W0A with `pready`: go to RUN, pulse `sw_done`, clear `sw_busy`, set `active_idx`.
- `sw_req` while `sw_busy`=1 is ignored; no queueing.
- `sw_req` to the current `active_idx` still performs the full sequence.

## Timing
**Reset values**
- `psel`, `penable`, `pwrite`, `sw_busy`, `sw_done` = 0.
- `paddr`=0, `pwdata`=0, `active_idx`=0, state=RUN, `in_frame`=0.
- `rst` mid-switch aborts the sequence. APB signals are low in the cycle after reset is sampled, and no `sw_done` is issued. The FIR shares `rst`, so its registers also return to 0, which is consistent with profile 0 at reset.

**Stall timing**
- With `pready` tied high, the stall lasts exactly 6 cycles (W2S..W0A).
- In the cycle after W0A, the state is RUN, `sw_done`=1 and `pass`=1.
- Each cycle of `pready`=0 in an xA state extends the stall by 1.

**Simultaneous events**
- `sw_req` in the same cycle as a tlast beat in RUN: `in_frame` clears. ARMED sees `in_frame`=0 and enters W2S on the next cycle.
- Acceptance latency: `sw_req` to first `psel` is 2 cycles when idle between frames.

**Other rules**
- No beat is accepted while `pass`=0, even if `s_tvalid`=1.
- `s_tvalid` may stay high throughout the stall; the held beat is forwarded unchanged when `pass` returns.
- APB outputs are registered (driven from state flops).

## Structure
- The shared package holds these constants:
  - FIR register offsets: `FIR_REG_GAIN`=0x0, `FIR_REG_COEF`=0x8, `FIR_REG_CTAP`=0xC.
  - The profile-word field positions.
  - The FSM state enum.
- One sub-module, `apb_wr_master`: a single-write SETUP/ACCESS engine with a start/done handshake. The FSM issues three sequential starts to it.

## Test plan
- Program profile 1 = {gain 2, c4 0x7F, coef 0x775F3F1C}, then `sw_req` idx 1 with the stream idle → APB writes 0x8←0x775F3F1C, 0xC←0x7F, 0x0←0x2. `sw_done` arrives 8 cycles after `sw_req`; `active_idx`=1.
- `sw_req` mid-frame with a 16-beat frame streaming → all 16 beats are forwarded, and `psel` rises only after the tlast handshake. `s_tready`=0 for exactly 6 cycles.
- `pready` held low for 3 cycles on the reg3 write → `penable` holds and the stall is 9 cycles. Addresses and data are unchanged.
- Second `sw_req` idx 2 while busy → ignored, only one sequence runs, and `active_idx` ends at the first index.
- `prof_we` to the selected index during W2A → the written data is the shadow value (the old profile).
- `rst` asserted in W3A → `psel`=0 next cycle, no `sw_done`, `active_idx`=0, and the stream passes again.
